// File: rtl/hit_monit_pkg.sv
// rtl/hit_monit_pkg.sv - shared types, constants and helpers for the hit monitor
package hit_monit_pkg;

    // Per-channel pulse-width FSM states
    typedef enum logic [1:0] {
        WST_IDLE = 2'd0,
        WST_MEAS = 2'd1,
        WST_LONG = 2'd2
    } wst_t;

    // Default legal pulse-width window, in clk_in cycles
    localparam int HIT_WIN_MIN = 4;
    localparam int HIT_WIN_MAX = 12;

    // Number of bits needed to index n items
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hit_monit_array_if.sv
// rtl/hit_monit_array_if.sv - control, hit and readout bundle of the hit monitor
interface hit_monit_array_if #(
    parameter int N_CH   = 13,
    parameter int SEL_W  = 4,
    parameter int CNT_W  = 32,
    parameter int WCNT_W = 5,
    parameter int ERR_W  = 8
);
    logic [N_CH-1:0]   hit_syn_in;
    logic [WCNT_W-1:0] win_min_in;
    logic [WCNT_W-1:0] win_max_in;
    logic              clr_in;
    logic              rd_in;
    logic              sel_mode_in;
    logic [SEL_W-1:0]  fix_sel_in;
    logic [SEL_W-1:0]  monit_sel_out;
    logic [CNT_W-1:0]  hit_cnt_out;
    logic [ERR_W-1:0]  err_short_cnt_out;
    logic [ERR_W-1:0]  err_long_cnt_out;
    logic              snap_valid_out;

    modport master (
        output hit_syn_in, win_min_in, win_max_in, clr_in, rd_in, sel_mode_in, fix_sel_in,
        input  monit_sel_out, hit_cnt_out, err_short_cnt_out, err_long_cnt_out, snap_valid_out
    );

    modport slave (
        input  hit_syn_in, win_min_in, win_max_in, clr_in, rd_in, sel_mode_in, fix_sel_in,
        output monit_sel_out, hit_cnt_out, err_short_cnt_out, err_long_cnt_out, snap_valid_out
    );
endinterface

// File: rtl/hit_width_chk.sv
// rtl/hit_width_chk.sv - one channel: edge detect, width FSM, hit and error counters
module hit_width_chk
    import hit_monit_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int WCNT_W   = 5,
    parameter int ERR_W    = 8,
    parameter int SAT_MODE = 0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              hit_in,
    input  logic              clr_in,
    input  logic [WCNT_W-1:0] win_min_in,
    input  logic [WCNT_W-1:0] win_max_in,
    output logic [CNT_W-1:0]  hit_cnt_out,
    output logic [ERR_W-1:0]  err_short_cnt_out,
    output logic [ERR_W-1:0]  err_long_cnt_out
);
    localparam logic [WCNT_W-1:0] W_ONE   = WCNT_W'(1);
    localparam logic [WCNT_W:0]   W1_ONE  = (WCNT_W + 1)'(1);
    localparam logic [CNT_W-1:0]  C_ONE   = CNT_W'(1);
    localparam logic [ERR_W-1:0]  E_ONE   = ERR_W'(1);

    // armed stays low for the first cycle after reset so a line already high is not a rise
    logic              armed;
    logic              prev;
    wst_t              state;
    logic [WCNT_W-1:0] w;
    logic              rise;
    logic              chk_en;
    logic [WCNT_W-1:0] w_inc;
    logic              short_err;
    logic              long_err;

    // Rise detection, saturating width increment and error decisions
    always_comb begin
        rise      = hit_in & ~prev & armed;
        chk_en    = (win_max_in != '0) && (win_min_in <= win_max_in);
        w_inc     = (w == '1) ? w : w + W_ONE;
        long_err  = chk_en && (state == WST_MEAS) && hit_in &&
                    ({1'b0, w_inc} == ({1'b0, win_max_in} + W1_ONE));
        short_err = chk_en && (state == WST_MEAS) && !hit_in && (w < win_min_in);
    end

    // Edge register and the three counters; clear wins over same-cycle events
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            armed             <= 1'b0;
            prev              <= 1'b0;
            hit_cnt_out       <= '0;
            err_short_cnt_out <= '0;
            err_long_cnt_out  <= '0;
        end else begin
            armed <= 1'b1;
            prev  <= hit_in;
            if (clr_in) begin
                hit_cnt_out       <= '0;
                err_short_cnt_out <= '0;
                err_long_cnt_out  <= '0;
            end else begin
                if (rise && !((SAT_MODE != 0) && (hit_cnt_out == '1))) begin
                    hit_cnt_out <= hit_cnt_out + C_ONE;
                end
                if (short_err && (err_short_cnt_out != '1)) begin
                    err_short_cnt_out <= err_short_cnt_out + E_ONE;
                end
                if (long_err && (err_long_cnt_out != '1)) begin
                    err_long_cnt_out <= err_long_cnt_out + E_ONE;
                end
            end
        end
    end

    // Pulse-width FSM: measure from the rise, stop counting once the pulse is too long
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= WST_IDLE;
            w     <= '0;
        end else if (clr_in) begin
            state <= WST_IDLE;
            w     <= '0;
        end else begin
            case (state)
                WST_IDLE: begin
                    if (rise) begin
                        w     <= W_ONE;
                        state <= WST_MEAS;
                    end
                end
                WST_MEAS: begin
                    if (hit_in) begin
                        w <= w_inc;
                        if (long_err) begin
                            state <= WST_LONG;
                        end
                    end else begin
                        state <= WST_IDLE;
                    end
                end
                WST_LONG: begin
                    if (!hit_in) begin
                        state <= WST_IDLE;
                    end
                end
                default: state <= WST_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/hit_monit_array.sv
// rtl/hit_monit_array.sv - N-channel hit monitor with pointer and snapshot readout
module hit_monit_array
    import hit_monit_pkg::*;
#(
    parameter int N_CH     = 13,
    parameter int SEL_W    = clog2(N_CH),
    parameter int CNT_W    = 32,
    parameter int WCNT_W   = 5,
    parameter int ERR_W    = 8,
    parameter int SAT_MODE = 0
) (
    input  logic            clk_in,
    input  logic            rst_in,
    hit_monit_array_if.slave bus
);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);
    localparam logic [SEL_W-1:0] S_ONE   = SEL_W'(1);

    logic [CNT_W-1:0] hit_cnt   [N_CH];
    logic [ERR_W-1:0] short_cnt [N_CH];
    logic [ERR_W-1:0] long_cnt  [N_CH];

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_next;
    logic             rd_prev;
    logic             rd_rise;
    logic             rd_fall;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        hit_width_chk #(
            .CNT_W   (CNT_W),
            .WCNT_W  (WCNT_W),
            .ERR_W   (ERR_W),
            .SAT_MODE(SAT_MODE)
        ) u_chk (
            .clk_in           (clk_in),
            .rst_in           (rst_in),
            .hit_in           (bus.hit_syn_in[g]),
            .clr_in           (bus.clr_in),
            .win_min_in       (bus.win_min_in),
            .win_max_in       (bus.win_max_in),
            .hit_cnt_out      (hit_cnt[g]),
            .err_short_cnt_out(short_cnt[g]),
            .err_long_cnt_out (long_cnt[g])
        );
    end

    // rd edges and next pointer: fixed select tracks fix_sel, auto rotates on rd fall
    always_comb begin
        rd_rise  = bus.rd_in & ~rd_prev;
        rd_fall  = ~bus.rd_in & rd_prev;
        ptr_next = ptr;
        if (bus.sel_mode_in) begin
            ptr_next = (32'(bus.fix_sel_in) < 32'(N_CH)) ? bus.fix_sel_in : '0;
        end else if (rd_fall) begin
            ptr_next = (ptr == LAST_CH) ? '0 : ptr + S_ONE;
        end
    end

    // Pointer, rd history and the snapshot registers taken on rd rise
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ptr                   <= '0;
            rd_prev               <= 1'b0;
            bus.hit_cnt_out       <= '0;
            bus.err_short_cnt_out <= '0;
            bus.err_long_cnt_out  <= '0;
            bus.snap_valid_out    <= 1'b0;
        end else begin
            ptr                <= ptr_next;
            rd_prev            <= bus.rd_in;
            bus.snap_valid_out <= rd_rise;
            if (rd_rise) begin
                bus.hit_cnt_out       <= hit_cnt[ptr];
                bus.err_short_cnt_out <= short_cnt[ptr];
                bus.err_long_cnt_out  <= long_cnt[ptr];
            end
        end
    end

    assign bus.monit_sel_out = ptr;
endmodule

// File: tb/tb_hit_monit_array.sv
// tb/tb_hit_monit_array.sv - directed table-driven bench for hit_monit_array
module tb_hit_monit_array;
    import hit_monit_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #10 clk_in = ~clk_in;

    hit_monit_array_if #(.N_CH(13), .SEL_W(4), .CNT_W(32), .WCNT_W(5), .ERR_W(8)) bus_m ();
    hit_monit_array_if #(.N_CH(2), .SEL_W(1), .CNT_W(4), .WCNT_W(5), .ERR_W(8)) bus_s ();
    hit_monit_array_if #(.N_CH(2), .SEL_W(1), .CNT_W(4), .WCNT_W(5), .ERR_W(8)) bus_w ();

    hit_monit_array #(.N_CH(13), .SEL_W(4), .CNT_W(32), .WCNT_W(5), .ERR_W(8), .SAT_MODE(0))
        dut_m (.clk_in(clk_in), .rst_in(rst_in), .bus(bus_m));
    hit_monit_array #(.N_CH(2), .SEL_W(1), .CNT_W(4), .WCNT_W(5), .ERR_W(8), .SAT_MODE(1))
        dut_s (.clk_in(clk_in), .rst_in(rst_in), .bus(bus_s));
    hit_monit_array #(.N_CH(2), .SEL_W(1), .CNT_W(4), .WCNT_W(5), .ERR_W(8), .SAT_MODE(0))
        dut_w (.clk_in(clk_in), .rst_in(rst_in), .bus(bus_w));

    // Both small instances share one stimulus
    logic [1:0] sm_hit = 2'b00;
    logic       sm_rd  = 1'b0;
    assign bus_s.hit_syn_in  = sm_hit;
    assign bus_s.win_min_in  = 5'(HIT_WIN_MIN);
    assign bus_s.win_max_in  = 5'(HIT_WIN_MAX);
    assign bus_s.clr_in      = 1'b0;
    assign bus_s.rd_in       = sm_rd;
    assign bus_s.sel_mode_in = 1'b1;
    assign bus_s.fix_sel_in  = 1'b0;
    assign bus_w.hit_syn_in  = sm_hit;
    assign bus_w.win_min_in  = 5'(HIT_WIN_MIN);
    assign bus_w.win_max_in  = 5'(HIT_WIN_MAX);
    assign bus_w.clr_in      = 1'b0;
    assign bus_w.rd_in       = sm_rd;
    assign bus_w.sel_mode_in = 1'b1;
    assign bus_w.fix_sel_in  = 1'b0;

    typedef struct {
        int ch;
        int width;
        int wmin;
        int wmax;
        int exp_hit;
        int exp_short;
        int exp_long;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse(input int ch, input int width);
        bus_m.hit_syn_in[ch] = 1'b1;
        repeat (width) tick();
        bus_m.hit_syn_in[ch] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic do_read(input string tag);
        bus_m.rd_in = 1'b1;
        tick();
        chk({tag, " snap_valid high"}, 32'(bus_m.snap_valid_out), 1);
        bus_m.rd_in = 1'b0;
        tick();
        chk({tag, " snap_valid low"}, 32'(bus_m.snap_valid_out), 0);
    endtask

    task automatic select_fixed(input int ch);
        bus_m.sel_mode_in = 1'b1;
        bus_m.fix_sel_in  = 4'(ch);
        tick();
    endtask

    task automatic read_expect(input string tag, input int ch, input int eh, input int es, input int el);
        select_fixed(ch);
        do_read(tag);
        chk({tag, " monit_sel"}, 32'(bus_m.monit_sel_out), 32'(ch));
        chk({tag, " hit_cnt"}, bus_m.hit_cnt_out, 32'(eh));
        chk({tag, " err_short"}, 32'(bus_m.err_short_cnt_out), 32'(es));
        chk({tag, " err_long"}, 32'(bus_m.err_long_cnt_out), 32'(el));
    endtask

    task automatic clear_all();
        bus_m.clr_in = 1'b1;
        tick();
        bus_m.clr_in = 1'b0;
        tick();
    endtask

    initial begin
        bus_m.hit_syn_in  = '0;
        bus_m.win_min_in  = 5'(HIT_WIN_MIN);
        bus_m.win_max_in  = 5'(HIT_WIN_MAX);
        bus_m.clr_in      = 1'b0;
        bus_m.rd_in       = 1'b0;
        bus_m.sel_mode_in = 1'b0;
        bus_m.fix_sel_in  = '0;

        vecs[0] = '{ch: 3,  width: 8,  wmin: 4, wmax: 12, exp_hit: 1, exp_short: 0, exp_long: 0};
        vecs[1] = '{ch: 0,  width: 2,  wmin: 4, wmax: 12, exp_hit: 1, exp_short: 1, exp_long: 0};
        vecs[2] = '{ch: 7,  width: 4,  wmin: 4, wmax: 12, exp_hit: 1, exp_short: 0, exp_long: 0};
        vecs[3] = '{ch: 8,  width: 3,  wmin: 4, wmax: 12, exp_hit: 1, exp_short: 1, exp_long: 0};
        vecs[4] = '{ch: 12, width: 12, wmin: 4, wmax: 12, exp_hit: 1, exp_short: 0, exp_long: 0};
        vecs[5] = '{ch: 11, width: 13, wmin: 4, wmax: 12, exp_hit: 1, exp_short: 0, exp_long: 1};
        vecs[6] = '{ch: 2,  width: 1,  wmin: 4, wmax: 12, exp_hit: 1, exp_short: 1, exp_long: 0};
        vecs[7] = '{ch: 4,  width: 2,  wmin: 8, wmax: 5,  exp_hit: 1, exp_short: 0, exp_long: 0};
        vecs[8] = '{ch: 6,  width: 20, wmin: 4, wmax: 0,  exp_hit: 1, exp_short: 0, exp_long: 0};
        vecs[9] = '{ch: 9,  width: 4,  wmin: 0, wmax: 3,  exp_hit: 1, exp_short: 0, exp_long: 1};

        // Reset state
        repeat (3) tick();
        rst_in = 1'b0;
        tick();
        chk("reset monit_sel", 32'(bus_m.monit_sel_out), 0);
        chk("reset hit_cnt", bus_m.hit_cnt_out, 0);
        chk("reset err_short", 32'(bus_m.err_short_cnt_out), 0);
        chk("reset err_long", 32'(bus_m.err_long_cnt_out), 0);
        chk("reset snap_valid", 32'(bus_m.snap_valid_out), 0);

        // Auto rotation: pointer seen at each rd is 0..12,0,1
        for (int k = 0; k < 14; k++) begin
            chk($sformatf("auto sel before rd %0d", k), 32'(bus_m.monit_sel_out), 32'(k % 13));
            do_read($sformatf("auto rd %0d", k));
        end

        // Table: one pulse per vector after a clear
        for (int i = 0; i < 10; i++) begin
            bus_m.win_min_in = 5'(vecs[i].wmin);
            bus_m.win_max_in = 5'(vecs[i].wmax);
            clear_all();
            pulse(vecs[i].ch, vecs[i].width);
            read_expect($sformatf("vec%0d", i), vecs[i].ch,
                        vecs[i].exp_hit, vecs[i].exp_short, vecs[i].exp_long);
        end

        // Short then stuck-long pulse on channel 0: one error of each kind
        bus_m.win_min_in = 5'(HIT_WIN_MIN);
        bus_m.win_max_in = 5'(HIT_WIN_MAX);
        clear_all();
        pulse(0, 2);
        pulse(0, 20);
        read_expect("ch0 short+long", 0, 2, 1, 1);

        // Clear coinciding with a rise on channel 5 loses that rise
        clear_all();
        bus_m.clr_in = 1'b1;
        bus_m.hit_syn_in[5] = 1'b1;
        tick();
        bus_m.clr_in = 1'b0;
        repeat (4) tick();
        bus_m.hit_syn_in[5] = 1'b0;
        repeat (3) tick();
        read_expect("clr vs rise", 5, 0, 0, 0);
        pulse(5, 6);
        read_expect("after clr", 5, 1, 0, 0);

        // Count overflow (saturate vs wrap) and short-error saturation
        for (int p = 0; p < 20; p++) begin
            sm_hit = 2'b01;
            tick();
            sm_hit = 2'b00;
            tick();
        end
        sm_rd = 1'b1;
        tick();
        sm_rd = 1'b0;
        tick();
        chk("sat hit_cnt 20", 32'(bus_s.hit_cnt_out), 15);
        chk("wrap hit_cnt 20", 32'(bus_w.hit_cnt_out), 4);
        chk("sat err_short 20", 32'(bus_s.err_short_cnt_out), 20);
        for (int p = 0; p < 280; p++) begin
            sm_hit = 2'b01;
            tick();
            sm_hit = 2'b00;
            tick();
        end
        sm_rd = 1'b1;
        tick();
        sm_rd = 1'b0;
        tick();
        chk("sat hit_cnt 300", 32'(bus_s.hit_cnt_out), 15);
        chk("wrap hit_cnt 300", 32'(bus_w.hit_cnt_out), 12);
        chk("sat err_short 300", 32'(bus_s.err_short_cnt_out), 255);
        chk("wrap err_short 300", 32'(bus_w.err_short_cnt_out), 255);
        chk("sat err_long 300", 32'(bus_s.err_long_cnt_out), 0);

        // Asynchronous reset in the middle of a pulse on channel 10
        pulse(10, 5);
        read_expect("ch10 before reset", 10, 1, 0, 0);
        bus_m.hit_syn_in[10] = 1'b1;
        repeat (3) tick();
        #3 rst_in = 1'b1;
        #1;
        chk("mid reset monit_sel", 32'(bus_m.monit_sel_out), 0);
        chk("mid reset hit_cnt", bus_m.hit_cnt_out, 0);
        chk("mid reset err_short", 32'(bus_m.err_short_cnt_out), 0);
        chk("mid reset err_long", 32'(bus_m.err_long_cnt_out), 0);
        chk("mid reset snap_valid", 32'(bus_m.snap_valid_out), 0);
        repeat (2) tick();
        rst_in = 1'b0;
        repeat (20) tick();
        bus_m.hit_syn_in[10] = 1'b0;
        repeat (3) tick();
        read_expect("ch10 after reset", 10, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
